// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   32 x 32-bit architectural register file. Each register has a pending-writer
//   counter that tracks in-flight writes. Register 0 always reads as zero and
//   is always valid.
//
//   Optional feature macro: WB_BYPASS_EN
//     Defined   - a same-cycle writeback is forwarded to a matching read port.
//     Undefined - read ports see only registered state.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   r1_addr/r2_addr     read port addresses
//   r1_data/r2_data     read port values (combinational)
//   r1_valid/r2_valid   value is final (no outstanding writer)
//   rsv_valid/rsv_addr  reserve a destination register at issue
//   rsv_ready           reservation of rsv_addr can be accepted this cycle
//   wb_valid/wb_addr/wb_data  writeback of one result
//   flush               clear all reservations
module regfile_scoreboard #(
   parameter int unsigned PEND_W = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  r1_addr,
   output logic        r1_valid,
   output logic [31:0] r1_data,
   input  logic [4:0]  r2_addr,
   output logic        r2_valid,
   output logic [31:0] r2_data,
   input  logic        rsv_valid,
   input  logic [4:0]  rsv_addr,
   output logic        rsv_ready,
   input  logic        wb_valid,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        flush
);

   localparam logic [PEND_W-1:0] PEND_MAX  = '1;
   localparam logic [PEND_W-1:0] PEND_ZERO = '0;
   localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

   // Entry 0 exists for uniform indexing but is never written.
   logic [31:0]       r_regs [32];
   logic [PEND_W-1:0] r_pend [32];
   logic [PEND_W-1:0] w_pend_nxt [32];

   logic w_rsv_take;
   logic w_wb_take;

   assign w_rsv_take = rsv_valid && rsv_ready && !flush && (rsv_addr != 5'd0);
   assign w_wb_take  = wb_valid && (wb_addr != 5'd0);

   // Independent of same-cycle writeback so issue logic sees a stable ready.
   assign rsv_ready = (rsv_addr == 5'd0) || (r_pend[rsv_addr] != PEND_MAX);

   // ------------------------------------------------------------------
   // Read ports
   // ------------------------------------------------------------------
   always_comb begin
      r1_data  = 32'd0;
      r1_valid = 1'b1;
      if (r1_addr != 5'd0) begin
         r1_data  = r_regs[r1_addr];
         r1_valid = (r_pend[r1_addr] == PEND_ZERO);
`ifdef WB_BYPASS_EN
         if (wb_valid && (wb_addr == r1_addr)) begin
            r1_data  = wb_data;
            r1_valid = (r_pend[r1_addr] <= PEND_ONE);
         end
`endif
      end
   end

   always_comb begin
      r2_data  = 32'd0;
      r2_valid = 1'b1;
      if (r2_addr != 5'd0) begin
         r2_data  = r_regs[r2_addr];
         r2_valid = (r_pend[r2_addr] == PEND_ZERO);
`ifdef WB_BYPASS_EN
         if (wb_valid && (wb_addr == r2_addr)) begin
            r2_data  = wb_data;
            r2_valid = (r_pend[r2_addr] <= PEND_ONE);
         end
`endif
      end
   end

   // ------------------------------------------------------------------
   // Pending counter next state
   // ------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < 32; i++) begin
         w_pend_nxt[i] = r_pend[i];
      end
      if (flush) begin
         // A writeback in the flush cycle has nothing left to retire.
         for (int i = 0; i < 32; i++) begin
            w_pend_nxt[i] = PEND_ZERO;
         end
      end else begin
         for (int i = 1; i < 32; i++) begin
            // Reserve and writeback of the same register cancel out.
            if (w_rsv_take && (rsv_addr == 5'(i)) &&
                !(w_wb_take && (wb_addr == 5'(i)))) begin
               w_pend_nxt[i] = r_pend[i] + PEND_ONE;
            end else if (w_wb_take && (wb_addr == 5'(i)) &&
                         !(w_rsv_take && (rsv_addr == 5'(i))) &&
                         (r_pend[i] != PEND_ZERO)) begin
               w_pend_nxt[i] = r_pend[i] - PEND_ONE;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            r_pend[i] <= PEND_ZERO;
         end
      end else begin
         for (int i = 0; i < 32; i++) begin
            r_pend[i] <= w_pend_nxt[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= 32'd0;
         end
      end else if (w_wb_take) begin
         r_regs[wb_addr] <= wb_data;
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed testbench for regfile_scoreboard (PEND_W = 2). Inputs change #1
// after a rising edge; outputs are sampled #2 after the edge.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  r1_addr, r2_addr, rsv_addr, wb_addr;
   logic        r1_valid, r2_valid, rsv_ready;
   logic [31:0] r1_data, r2_data, wb_data;
   logic        rsv_valid, wb_valid, flush;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   regfile_scoreboard #(.PEND_W(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .r1_addr   (r1_addr),
      .r1_valid  (r1_valid),
      .r1_data   (r1_data),
      .r2_addr   (r2_addr),
      .r2_valid  (r2_valid),
      .r2_data   (r2_data),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .rsv_ready (rsv_ready),
      .wb_valid  (wb_valid),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .flush     (flush)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rsv_valid = 1'b0;
      wb_valid  = 1'b0;
      flush     = 1'b0;
      reset     = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; rsv_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
      rsv_addr = 5'd3; wb_addr = 5'd0; wb_data = 32'd0;
      r1_addr = 5'd5; r2_addr = 5'd31;
      tick(); tick();
      idle();
      #1;
      n_total++;
      if (r1_data !== 32'd0 || r1_valid !== 1'b1)
         $display("FAIL reset_r5: got data=%h valid=%b want data=0 valid=1", r1_data, r1_valid);
      else n_pass++;
      n_total++;
      if (r2_data !== 32'd0 || r2_valid !== 1'b1)
         $display("FAIL reset_r31: got data=%h valid=%b want data=0 valid=1", r2_data, r2_valid);
      else n_pass++;
      n_total++;
      if (rsv_ready !== 1'b1)
         $display("FAIL reset_rsv_ready: got %b want 1", rsv_ready);
      else n_pass++;
   endtask

   task automatic test_raw();
      // T: reserve r3
      rsv_valid = 1'b1; rsv_addr = 5'd3; r1_addr = 5'd3;
      tick();
      // T+1
      idle();
      #1;
      n_total++;
      if (r1_valid !== 1'b0)
         $display("FAIL raw_t1_valid: got %b want 0", r1_valid);
      else n_pass++;
      tick();
      // T+2: writeback
      wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234_5678;
      #1;
`ifdef WB_BYPASS_EN
      n_total++;
      if (r1_valid !== 1'b1 || r1_data !== 32'h1234_5678)
         $display("FAIL raw_t2_bypass: got data=%h valid=%b want data=12345678 valid=1",
                  r1_data, r1_valid);
      else n_pass++;
`else
      n_total++;
      if (r1_valid !== 1'b0 || r1_data !== 32'd0)
         $display("FAIL raw_t2: got data=%h valid=%b want data=0 valid=0", r1_data, r1_valid);
      else n_pass++;
`endif
      tick();
      // T+3
      idle();
      #1;
      n_total++;
      if (r1_valid !== 1'b1 || r1_data !== 32'h1234_5678)
         $display("FAIL raw_t3: got data=%h valid=%b want data=12345678 valid=1",
                  r1_data, r1_valid);
      else n_pass++;
   endtask

   task automatic test_saturate();
      r1_addr = 5'd7;
      for (int k = 0; k < 3; k++) begin
         rsv_valid = 1'b1; rsv_addr = 5'd7;
         #1;
         n_total++;
         if (rsv_ready !== 1'b1)
            $display("FAIL sat_ready_%0d: got %b want 1", k, rsv_ready);
         else n_pass++;
         tick();
      end
      // Fourth reservation must be refused and dropped.
      rsv_valid = 1'b1; rsv_addr = 5'd7;
      #1;
      n_total++;
      if (rsv_ready !== 1'b0)
         $display("FAIL sat_full_ready: got %b want 0", rsv_ready);
      else n_pass++;
      tick();
      idle();
      for (int k = 0; k < 3; k++) begin
         wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'(k + 1);
         tick();
         idle();
         #1;
         n_total++;
         if (k < 2 && r1_valid !== 1'b0)
            $display("FAIL sat_wb_%0d_valid: got %b want 0", k, r1_valid);
         else if (k == 2 && (r1_valid !== 1'b1 || r1_data !== 32'd3))
            $display("FAIL sat_wb_last: got data=%h valid=%b want data=3 valid=1",
                     r1_data, r1_valid);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_same_cycle();
      r1_addr = 5'd9;
      rsv_valid = 1'b1; rsv_addr = 5'd9;
      tick();
      // pend[9]=1; reserve and writeback together
      rsv_valid = 1'b1; rsv_addr = 5'd9;
      wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0099;
      #1;
      n_total++;
      if (rsv_ready !== 1'b1)
         $display("FAIL same_ready: got %b want 1", rsv_ready);
      else n_pass++;
      tick();
      idle();
      #1;
      n_total++;
      if (r1_valid !== 1'b0 || r1_data !== 32'h0000_0099)
         $display("FAIL same_after: got data=%h valid=%b want data=99 valid=0",
                  r1_data, r1_valid);
      else n_pass++;
      tick();
      wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_009A;
      tick();
      idle();
      #1;
      n_total++;
      if (r1_valid !== 1'b1 || r1_data !== 32'h0000_009A)
         $display("FAIL same_final: got data=%h valid=%b want data=9a valid=1",
                  r1_data, r1_valid);
      else n_pass++;
      tick();
   endtask

   task automatic test_flush();
      rsv_valid = 1'b1; rsv_addr = 5'd4;
      tick();
      rsv_valid = 1'b1; rsv_addr = 5'd5;
      tick();
      idle();
      r1_addr = 5'd4; r2_addr = 5'd5;
      #1;
      n_total++;
      if (r1_valid !== 1'b0 || r2_valid !== 1'b0)
         $display("FAIL flush_pre: got v4=%b v5=%b want 0 0", r1_valid, r2_valid);
      else n_pass++;
      flush = 1'b1;
      rsv_valid = 1'b1; rsv_addr = 5'd8;
      wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'h0000_00AA;
      tick();
      idle();
      #1;
      n_total++;
      if (r1_valid !== 1'b1 || r2_valid !== 1'b1)
         $display("FAIL flush_r4r5: got v4=%b v5=%b want 1 1", r1_valid, r2_valid);
      else n_pass++;
      r1_addr = 5'd8; r2_addr = 5'd6;
      #1;
      n_total++;
      if (r1_valid !== 1'b1)
         $display("FAIL flush_r8: got valid=%b want 1", r1_valid);
      else n_pass++;
      n_total++;
      if (r2_valid !== 1'b1 || r2_data !== 32'h0000_00AA)
         $display("FAIL flush_r6: got data=%h valid=%b want data=aa valid=1",
                  r2_data, r2_valid);
      else n_pass++;
      tick();
   endtask

   task automatic test_r0();
      rsv_valid = 1'b1; rsv_addr = 5'd0;
      wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
      r1_addr = 5'd0;
      #1;
      n_total++;
      if (rsv_ready !== 1'b1)
         $display("FAIL r0_ready: got %b want 1", rsv_ready);
      else n_pass++;
      tick();
      idle();
      r2_addr = 5'd3;
      #1;
      n_total++;
      if (r1_data !== 32'd0 || r1_valid !== 1'b1)
         $display("FAIL r0_read: got data=%h valid=%b want data=0 valid=1", r1_data, r1_valid);
      else n_pass++;
      n_total++;
      if (r2_data !== 32'h1234_5678 || r2_valid !== 1'b1)
         $display("FAIL r0_r3_kept: got data=%h valid=%b want data=12345678 valid=1",
                  r2_data, r2_valid);
      else n_pass++;
      r2_addr = 5'd9;
      #1;
      n_total++;
      if (r2_data !== 32'h0000_009A)
         $display("FAIL r0_r9_kept: got data=%h want 9a", r2_data);
      else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      // Writeback to an idle register must not underflow its counter.
      wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'h0000_0C0C;
      tick();
      idle();
      rsv_valid = 1'b1; rsv_addr = 5'd12;
      tick();
      idle();
      r1_addr = 5'd12;
      #1;
      n_total++;
      if (r1_valid !== 1'b0 || r1_data !== 32'h0000_0C0C)
         $display("FAIL noundf_r12: got data=%h valid=%b want data=c0c valid=0",
                  r1_data, r1_valid);
      else n_pass++;
      tick();
      // Reset wins over writeback and reservation in the same cycle.
      reset = 1'b1;
      wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'h0000_0005;
      rsv_valid = 1'b1; rsv_addr = 5'd11;
      tick();
      idle();
      r1_addr = 5'd10; r2_addr = 5'd11;
      #1;
      n_total++;
      if (r1_data !== 32'd0 || r2_valid !== 1'b1)
         $display("FAIL rst_override: got d10=%h v11=%b want 0 1", r1_data, r2_valid);
      else n_pass++;
      r1_addr = 5'd12; r2_addr = 5'd3;
      #1;
      n_total++;
      if (r1_valid !== 1'b1 || r2_data !== 32'd0)
         $display("FAIL rst_clears: got v12=%b d3=%h want 1 0", r1_valid, r2_data);
      else n_pass++;
      tick();
   endtask

   initial begin
      test_reset();
      test_raw();
      test_saturate();
      test_same_cycle();
      test_flush();
      test_r0();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
